// File: rtl/alu_arbiter.sv
// alu_arbiter: round-robin sharing of one external ALU between two requesters.
// Each requester has a valid/ready request channel and a valid/ready response
// channel. One operation is in flight at a time: IDLE accepts, EXEC drives the
// ALU from the operand registers, RESP holds the captured result for the owner.
//
//   state | meaning
//   ------+--------------------------------------------------------------
//   IDLE  | no op in flight; granted requester sees ready
//   EXEC  | operand registers drive the ALU; result captured at cycle end
//   RESP  | result presented to the owner until it takes it
module alu_arbiter #(
    parameter int WIDTH  = 32,
    parameter int CTRL_W = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic [WIDTH-1:0]  req0_entrada1,
    input  logic [WIDTH-1:0]  req0_entrada2,
    input  logic [CTRL_W-1:0] req0_alu_control,

    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic [WIDTH-1:0]  req1_entrada1,
    input  logic [WIDTH-1:0]  req1_entrada2,
    input  logic [CTRL_W-1:0] req1_alu_control,

    output logic              resp0_valid,
    input  logic              resp0_ready,
    output logic              resp1_valid,
    input  logic              resp1_ready,
    output logic [WIDTH-1:0]  resp_resultado,
    output logic              resp_zero,

    output logic [WIDTH-1:0]  alu_entrada1,
    output logic [WIDTH-1:0]  alu_entrada2,
    output logic [CTRL_W-1:0] alu_control,
    input  logic [WIDTH-1:0]  alu_resultado,
    input  logic              alu_zero,

    output logic              busy,
    output logic [CNT_W-1:0]  cnt0,
    output logic [CNT_W-1:0]  cnt1
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    state_t              state;
    state_t              state_next;
    logic                owner;
    logic                last_grant;
    logic [WIDTH-1:0]    op1_q;
    logic [WIDTH-1:0]    op2_q;
    logic [CTRL_W-1:0]   ctrl_q;
    logic                grant0;
    logic                grant1;
    logic                accept;
    logic                resp_done;

    assign alu_entrada1 = op1_q;
    assign alu_entrada2 = op2_q;
    assign alu_control  = ctrl_q;
    assign busy         = (state != IDLE);

    // Round-robin pick: a lone requester always wins; on a tie the one that
    // was not served last wins (last_grant resets to 1 so req0 wins first).
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // State register.
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and handshake outputs.
    always_comb begin
        state_next  = state;
        req0_ready  = 1'b0;
        req1_ready  = 1'b0;
        resp0_valid = 1'b0;
        resp1_valid = 1'b0;
        accept      = 1'b0;
        resp_done   = 1'b0;
        case (state)
            IDLE: begin
                req0_ready = grant0;
                req1_ready = grant1;
                if (grant0 || grant1) begin
                    accept     = 1'b1;
                    state_next = EXEC;
                end
            end
            EXEC: begin
                state_next = RESP;
            end
            RESP: begin
                resp0_valid = !owner;
                resp1_valid = owner;
                resp_done   = owner ? resp1_ready : resp0_ready;
                if (resp_done) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Operand capture on accept, result capture at the end of EXEC, and
    // saturating completion counters on the response handshake.
    always_ff @(posedge clk) begin
        if (reset) begin
            owner          <= 1'b0;
            last_grant     <= 1'b1;
            op1_q          <= '0;
            op2_q          <= '0;
            ctrl_q         <= '0;
            resp_resultado <= '0;
            resp_zero      <= 1'b0;
            cnt0           <= '0;
            cnt1           <= '0;
        end else begin
            if (accept) begin
                owner      <= grant1;
                last_grant <= grant1;
                op1_q      <= grant1 ? req1_entrada1    : req0_entrada1;
                op2_q      <= grant1 ? req1_entrada2    : req0_entrada2;
                ctrl_q     <= grant1 ? req1_alu_control : req0_alu_control;
            end
            if (state == EXEC) begin
                resp_resultado <= alu_resultado;
                resp_zero      <= alu_zero;
            end
            if (resp_done) begin
                if (!owner && (cnt0 != CNT_MAX)) begin
                    cnt0 <= cnt0 + CNT_ONE;
                end
                if (owner && (cnt1 != CNT_MAX)) begin
                    cnt1 <= cnt1 + CNT_ONE;
                end
            end
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// Testbench for alu_arbiter: directed vector table, hand-written multi-cycle
// sequences (tie alternation, backpressure, mid-op reset) and a randomized
// run against a cycle-timeline reference model. The shared ALU is modelled
// here as plain combinational arithmetic.
module tb_alu_arbiter;

    localparam int WIDTH  = 32;
    localparam int CTRL_W = 4;
    localparam int CNT_W  = 2;

    localparam logic [3:0] OP_AND = 4'b0000;
    localparam logic [3:0] OP_OR  = 4'b0001;
    localparam logic [3:0] OP_ADD = 4'b0010;
    localparam logic [3:0] OP_SUB = 4'b0110;
    localparam logic [3:0] OP_SLT = 4'b0111;
    localparam logic [3:0] OP_NOR = 4'b1100;

    logic              clk = 1'b0;
    logic              reset;
    logic              req0_valid, req1_valid;
    logic              req0_ready, req1_ready;
    logic [WIDTH-1:0]  req0_entrada1, req0_entrada2, req1_entrada1, req1_entrada2;
    logic [CTRL_W-1:0] req0_alu_control, req1_alu_control;
    logic              resp0_valid, resp1_valid, resp0_ready, resp1_ready;
    logic [WIDTH-1:0]  resp_resultado;
    logic              resp_zero;
    logic [WIDTH-1:0]  alu_entrada1, alu_entrada2, alu_resultado;
    logic [CTRL_W-1:0] alu_control;
    logic              alu_zero;
    logic              busy;
    logic [CNT_W-1:0]  cnt0, cnt1;

    int tests = 0;
    int fails = 0;

    alu_arbiter #(.WIDTH(WIDTH), .CTRL_W(CTRL_W), .CNT_W(CNT_W)) dut (
        .clk(clk), .reset(reset),
        .req0_valid(req0_valid), .req0_ready(req0_ready),
        .req0_entrada1(req0_entrada1), .req0_entrada2(req0_entrada2),
        .req0_alu_control(req0_alu_control),
        .req1_valid(req1_valid), .req1_ready(req1_ready),
        .req1_entrada1(req1_entrada1), .req1_entrada2(req1_entrada2),
        .req1_alu_control(req1_alu_control),
        .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
        .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
        .resp_resultado(resp_resultado), .resp_zero(resp_zero),
        .alu_entrada1(alu_entrada1), .alu_entrada2(alu_entrada2),
        .alu_control(alu_control), .alu_resultado(alu_resultado),
        .alu_zero(alu_zero), .busy(busy), .cnt0(cnt0), .cnt1(cnt1)
    );

    always #5 clk = ~clk;

    function automatic logic [WIDTH-1:0] alu_fn(input logic [3:0] c,
                                                input logic [WIDTH-1:0] a,
                                                input logic [WIDTH-1:0] b);
        case (c)
            OP_AND:  return a & b;
            OP_OR:   return a | b;
            OP_ADD:  return a + b;
            OP_SUB:  return a - b;
            OP_SLT:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            OP_NOR:  return ~(a | b);
            default: return '0;
        endcase
    endfunction

    assign alu_resultado = alu_fn(alu_control, alu_entrada1, alu_entrada2);
    assign alu_zero      = (alu_resultado == '0);

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive_req(input int n, input logic v, input logic [3:0] c,
                             input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
        if (n == 0) begin
            req0_valid = v; req0_alu_control = c; req0_entrada1 = a; req0_entrada2 = b;
        end else begin
            req1_valid = v; req1_alu_control = c; req1_entrada1 = a; req1_entrada2 = b;
        end
    endtask

    task automatic set_resp_ready(input int n, input logic v);
        if (n == 0) resp0_ready = v;
        else        resp1_ready = v;
    endtask

    function automatic logic rdy(input int n);
        return (n == 0) ? req0_ready : req1_ready;
    endfunction

    function automatic logic rvalid(input int n);
        return (n == 0) ? resp0_valid : resp1_valid;
    endfunction

    function automatic logic [CNT_W-1:0] cnt_of(input int n);
        return (n == 0) ? cnt0 : cnt1;
    endfunction

    task automatic idle_inputs();
        drive_req(0, 1'b0, 4'd0, '0, '0);
        drive_req(1, 1'b0, 4'd0, '0, '0);
        resp0_ready = 1'b0;
        resp1_ready = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        reset = 1'b0;
    endtask

    typedef struct {
        int               sel;
        logic [3:0]       ctrl;
        logic [WIDTH-1:0] a;
        logic [WIDTH-1:0] b;
        logic [WIDTH-1:0] res;
        logic             z;
        logic [CNT_W-1:0] cnt;
    } vec_t;

    // One complete single-requester transaction with cycle-exact checks.
    task automatic run_op(input vec_t v);
        int n = v.sel;
        @(negedge clk);
        drive_req(n, 1'b1, v.ctrl, v.a, v.b);
        #1;
        check("op_req_ready", rdy(n), 1);
        check("op_other_ready", rdy(1 - n), 0);
        @(negedge clk);
        drive_req(n, 1'b0, 4'd0, '0, '0);
        #1;
        check("op_busy", busy, 1);
        check("op_alu_entrada1", alu_entrada1, v.a);
        check("op_alu_entrada2", alu_entrada2, v.b);
        check("op_alu_control", alu_control, v.ctrl);
        check("op_no_early_resp", {resp1_valid, resp0_valid}, 0);
        @(negedge clk);
        set_resp_ready(n, 1'b1);
        #1;
        check("op_resp_valid", rvalid(n), 1);
        check("op_other_resp_valid", rvalid(1 - n), 0);
        check("op_resultado", resp_resultado, v.res);
        check("op_zero", resp_zero, v.z);
        @(negedge clk);
        set_resp_ready(n, 1'b0);
        #1;
        check("op_idle_busy", busy, 0);
        check("op_cnt", cnt_of(n), v.cnt);
    endtask

    task automatic reset_mid(input int stage);
        vec_t v;
        do_reset();
        @(negedge clk);
        drive_req(0, 1'b1, OP_ADD, 32'd5, 32'd3);
        @(negedge clk);
        drive_req(0, 1'b0, 4'd0, '0, '0);
        if (stage == 2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        #1;
        check("rst_mid_busy", busy, 0);
        check("rst_mid_resp_valid", {resp1_valid, resp0_valid}, 0);
        check("rst_mid_cnt0", cnt0, 0);
        v = '{sel: 0, ctrl: OP_ADD, a: 32'd5, b: 32'd3, res: 32'd8, z: 1'b0, cnt: 2'd1};
        run_op(v);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    vec_t tbl[6];
    logic [3:0] ops[6];

    initial begin
        tbl[0] = '{sel: 0, ctrl: OP_ADD, a: 32'd5,        b: 32'd3,  res: 32'd8,          z: 1'b0, cnt: 2'd1};
        tbl[1] = '{sel: 1, ctrl: OP_SUB, a: 32'd7,        b: 32'd7,  res: 32'd0,          z: 1'b1, cnt: 2'd1};
        tbl[2] = '{sel: 0, ctrl: OP_SLT, a: 32'hFFFFFFFF, b: 32'd1,  res: 32'd1,          z: 1'b0, cnt: 2'd2};
        tbl[3] = '{sel: 1, ctrl: OP_OR,  a: 32'hF0,       b: 32'h0F, res: 32'hFF,         z: 1'b0, cnt: 2'd2};
        tbl[4] = '{sel: 0, ctrl: OP_AND, a: 32'hF0,       b: 32'h3C, res: 32'h30,         z: 1'b0, cnt: 2'd3};
        tbl[5] = '{sel: 0, ctrl: OP_NOR, a: 32'd0,        b: 32'd0,  res: 32'hFFFFFFFF,   z: 1'b0, cnt: 2'd3};
        ops = '{OP_AND, OP_OR, OP_ADD, OP_SUB, OP_SLT, OP_NOR};

        reset = 1'b1;
        idle_inputs();
        @(negedge clk);
        @(negedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_req_ready", {req1_ready, req0_ready}, 0);
        check("rst_resp_valid", {resp1_valid, resp0_valid}, 0);
        check("rst_cnt0", cnt0, 0);
        check("rst_cnt1", cnt1, 0);
        check("rst_alu_entrada1", alu_entrada1, 0);
        check("rst_alu_control", alu_control, 0);
        check("rst_resultado", resp_resultado, 0);
        reset = 1'b0;

        // Directed table; entries 4 and 5 are cnt0's 3rd and 4th completions.
        foreach (tbl[i]) run_op(tbl[i]);

        // Both requesters held valid: strict alternation starting with req0.
        do_reset();
        @(negedge clk);
        drive_req(0, 1'b1, OP_AND, 32'hF0, 32'h3C);
        drive_req(1, 1'b1, OP_OR,  32'hF0, 32'h0F);
        resp0_ready = 1'b1;
        resp1_ready = 1'b1;
        #1;
        for (int k = 0; k < 4; k++) begin
            int waited = 0;
            while (!(req0_ready || req1_ready) && waited < 6) begin
                @(negedge clk);
                #1;
                waited++;
            end
            check("alt_issue_gap", waited, 0);
            check("alt_grant", {req1_ready, req0_ready}, (k % 2 == 1) ? 2 : 1);
            @(negedge clk);
            #1;
            @(negedge clk);
            #1;
            check("alt_resp_valid", {resp1_valid, resp0_valid}, (k % 2 == 1) ? 2 : 1);
            check("alt_resultado", resp_resultado, (k % 2 == 1) ? 32'hFF : 32'h30);
            check("alt_ready_low_in_resp", {req1_ready, req0_ready}, 0);
            @(negedge clk);
            #1;
        end
        idle_inputs();

        // Backpressure on req0's response while req1 waits.
        do_reset();
        @(negedge clk);
        drive_req(0, 1'b1, OP_SLT, 32'hFFFFFFFF, 32'd1);
        #1;
        check("bp_req0_ready", req0_ready, 1);
        @(negedge clk);
        drive_req(0, 1'b0, 4'd0, '0, '0);
        drive_req(1, 1'b1, OP_OR, 32'hF0, 32'h0F);
        #1;
        check("bp_exec_ready", {req1_ready, req0_ready}, 0);
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            #1;
            check("bp_resp0_valid", resp0_valid, 1);
            check("bp_resp1_valid", resp1_valid, 0);
            check("bp_resultado", resp_resultado, 1);
            check("bp_ready_blocked", {req1_ready, req0_ready}, 0);
        end
        @(negedge clk);
        resp0_ready = 1'b1;
        #1;
        check("bp_release_valid", resp0_valid, 1);
        @(negedge clk);
        resp0_ready = 1'b0;
        #1;
        check("bp_req1_granted", {req1_ready, req0_ready}, 2);
        check("bp_cnt0", cnt0, 1);
        @(negedge clk);
        drive_req(1, 1'b0, 4'd0, '0, '0);
        resp1_ready = 1'b1;
        @(negedge clk);
        #1;
        check("bp_req1_resp", resp1_valid, 1);
        check("bp_req1_resultado", resp_resultado, 32'hFF);
        @(negedge clk);
        idle_inputs();

        reset_mid(1);
        reset_mid(2);

        // Randomized traffic against a cycle-timeline reference model.
        do_reset();
        begin
            bit               inf = 0;
            int               acc = 0;
            int               own = 0;
            int               last = 1;
            int               g;
            int               phase;
            int               mcnt[2] = '{0, 0};
            bit               pend[2] = '{0, 0};
            logic [WIDTH-1:0] pa[2], pb[2];
            logic [3:0]       pc[2];
            logic [WIDTH-1:0] ea, eb, eres;
            logic [3:0]       ec;
            logic             rr[2];
            for (int cyc = 0; cyc < 400; cyc++) begin
                @(negedge clk);
                for (int n = 0; n < 2; n++) begin
                    if (!pend[n] && $urandom_range(1) == 1) begin
                        pend[n] = 1;
                        pa[n] = $urandom;
                        pb[n] = ($urandom_range(3) == 0) ? pa[n] : $urandom;
                        pc[n] = ops[$urandom_range(5)];
                    end else if (pend[n] && $urandom_range(9) == 0) begin
                        pend[n] = 0;
                    end
                    drive_req(n, pend[n], pc[n], pa[n], pb[n]);
                    rr[n] = ($urandom_range(2) != 0);
                    set_resp_ready(n, rr[n]);
                end
                #1;
                g = -1;
                if (!inf) begin
                    if (pend[0] && pend[1]) g = (last == 0) ? 1 : 0;
                    else if (pend[0])       g = 0;
                    else if (pend[1])       g = 1;
                end
                phase = inf ? (cyc - acc) : -1;
                check("rnd_req0_ready", req0_ready, (g == 0));
                check("rnd_req1_ready", req1_ready, (g == 1));
                check("rnd_busy", busy, inf);
                check("rnd_resp0_valid", resp0_valid, (inf && phase >= 2 && own == 0));
                check("rnd_resp1_valid", resp1_valid, (inf && phase >= 2 && own == 1));
                if (inf && phase == 1) begin
                    check("rnd_alu_entrada1", alu_entrada1, ea);
                    check("rnd_alu_entrada2", alu_entrada2, eb);
                    check("rnd_alu_control", alu_control, ec);
                end
                if (inf && phase >= 2) begin
                    check("rnd_resultado", resp_resultado, eres);
                    check("rnd_zero", resp_zero, (eres == '0));
                end
                check("rnd_cnt0", cnt0, mcnt[0]);
                check("rnd_cnt1", cnt1, mcnt[1]);
                if (g >= 0) begin
                    inf = 1; acc = cyc; own = g; last = g;
                    ea = pa[g]; eb = pb[g]; ec = pc[g];
                    eres = alu_fn(ec, ea, eb);
                    pend[g] = 0;
                end else if (inf && phase >= 2 && rr[own]) begin
                    if (mcnt[own] < (1 << CNT_W) - 1) mcnt[own]++;
                    inf = 0;
                end
            end
        end
        @(negedge clk);
        idle_inputs();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one `alu` instance between two requesters (req0, req1) using round-robin arbitration.
- Per requester: valid/ready request channel and valid/ready response channel.
- The ALU is instantiated outside this block. This block drives its operands and control and captures `resultado`/`zero`.
- Sits between the pipeline's integer issue logic and the shared ALU.

Parameters:
- WIDTH, 32, operand/result width.
- CTRL_W, 4, ALU control width.
- CNT_W, 16, width of the per-requester completed-operation counters.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  synchronous, active-high reset.
- req0_valid, req1_valid  input  1  request present.
- req0_ready, req1_ready  output  1  request accepted this cycle when valid&ready.
- req0_entrada1, req1_entrada1  input  WIDTH  operand 1.
- req0_entrada2, req1_entrada2  input  WIDTH  operand 2.
- req0_alu_control, req1_alu_control  input  CTRL_W  ALU opcode.
- resp0_valid, resp1_valid  output  1  result available.
- resp0_ready, resp1_ready  input  1  requester takes result.
- resp_resultado  output  WIDTH  captured result (shared; qualified by respN_valid).
- resp_zero  output  1  captured zero flag.
- alu_entrada1, alu_entrada2  output  WIDTH  to ALU.
- alu_control  output  CTRL_W  to ALU.
- alu_resultado  input  WIDTH  from ALU.
- alu_zero  input  1  from ALU.
- busy  output  1  state != IDLE.
- cnt0, cnt1  output  CNT_W  completed ops per requester, saturating.

Behaviour:

Reset:
- Synchronous, active-high: state=IDLE, last_grant=1 (so req0 wins the first tie).
- All ready/valid outputs 0; operand/control/result registers 0; busy=0; cnt0=cnt1=0.
- Reset mid-operation abandons the transaction: no response is issued and counters are not incremented.

FSM states:
- IDLE:
  - reqN_ready is combinational. It is high only for the granted requester, and only in IDLE.
  - Grant rule: if exactly one valid, grant it. If both valid, grant the requester != last_grant. If none valid, both ready=0.
  - On handshake: register entrada1/entrada2/alu_control into the operand registers, record owner, set last_grant=owner, go to EXEC.
- EXEC:
  - alu_* outputs are driven from the operand registers (they are always driven from them; they hold last values otherwise).
  - At end of cycle, capture alu_resultado into resp_resultado and alu_zero into resp_zero. Go to RESP.
- RESP:
  - resp<owner>_valid=1; the other resp valid=0.
  - On resp<owner>_ready=1: increment cnt<owner> unless at all-ones, then go to IDLE.
  - Otherwise hold: all outputs stable, both req ready=0.

Timing and handshake rules:
- Latency: handshake at cycle T → resp valid at T+2.
- Minimum issue interval is 3 cycles; no new request is accepted in the cycle a response completes (next accept in IDLE at T+3 at the earliest).
- Requesters must hold valid and payload stable until ready. Valid must not depend on ready. Ready may depend on valid.
- resp_valid never asserts for a requester that did not issue the current op.

Boundary conditions:
- A request deasserted before acceptance is legal and ignored.
- A counter at 2^CNT_W-1 stays there.

Test Plan:
- Reset, then req0 ADD (0010) 5+3 at cycle T → req0_ready=1 at T; alu_entrada1=5, alu_entrada2=3 at T+1; resp0_valid=1, resp_resultado=8, resp_zero=0 at T+2; resp0_ready=1 → IDLE, cnt0=1.
- After reset, both valid in the same cycle (req0 AND 0xF0&0x3C, req1 OR 0xF0|0x0F), both held valid with resp ready=1 → req0 served first (0x30), then req1 (0xFF). Re-present both → req0 wins again (last_grant=1); one more cycle → req1, i.e. strict alternation.
- req1 SUB 7-7 → resp1_valid with resp_resultado=0, resp_zero=1; resp0_valid stays 0 throughout.
- Backpressure: req0 SLT -1<1 (0111) with resp0_ready=0 for 4 cycles → resp0_valid=1 and resp_resultado=1 stable all 4 cycles; req0_ready and req1_ready=0 while req1_valid=1; release → IDLE, req1 granted next cycle.
- Reset asserted in EXEC, then in RESP (separate runs) → next cycle state IDLE, resp valids 0, cnt unchanged at 0, busy=0; a subsequent request completes normally.
- Force cnt0 to saturation with CNT_W=2 (4 ops) → cnt0=3 after the 3rd and 4th completions.
